// File: rtl/vmicro16_branch_resolve_pkg.sv
// Shared definitions for the vmicro16 branch-resolution stage: branch
// condition codes, status-flag bit positions and the resolver state encoding.
package vmicro16_branch_resolve_pkg;

    localparam logic [7:0] VMICRO16_OP_BR_U  = 8'h00;
    localparam logic [7:0] VMICRO16_OP_BR_E  = 8'h01;
    localparam logic [7:0] VMICRO16_OP_BR_NE = 8'h02;
    localparam logic [7:0] VMICRO16_OP_BR_G  = 8'h03;
    localparam logic [7:0] VMICRO16_OP_BR_GE = 8'h04;
    localparam logic [7:0] VMICRO16_OP_BR_L  = 8'h05;
    localparam logic [7:0] VMICRO16_OP_BR_LE = 8'h06;

    localparam int VMICRO16_SFLAG_N = 3;
    localparam int VMICRO16_SFLAG_Z = 2;
    localparam int VMICRO16_SFLAG_C = 1;
    localparam int VMICRO16_SFLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_EVAL = 2'd2
    } br_state_t;

endpackage

// File: rtl/vmicro16_branch_resolve_if.sv
// Compare/branch/redirect signal bundle between the execute, branch-resolve
// and fetch sides. The master drives requests; the slave is the resolver.
interface vmicro16_branch_resolve_if #(
    parameter int PC_WIDTH = 16,
    parameter int CNT_W    = 2
);
    logic                cmp_issue;
    logic                cmp_valid;
    logic [3:0]          cmp_flags;
    logic                br_valid;
    logic                br_ready;
    logic [7:0]          br_cond;
    logic [PC_WIDTH-1:0] br_target;
    logic                redirect_valid;
    logic [PC_WIDTH-1:0] redirect_pc;
    logic                flush;
    logic                br_done;
    logic                br_taken;
    logic [3:0]          flags;
    logic                err;
    logic [CNT_W-1:0]    pending;

    modport master (
        output cmp_issue, cmp_valid, cmp_flags, br_valid, br_cond, br_target,
        input  br_ready, redirect_valid, redirect_pc, flush, br_done, br_taken,
               flags, err, pending
    );

    modport slave (
        input  cmp_issue, cmp_valid, cmp_flags, br_valid, br_cond, br_target,
        output br_ready, redirect_valid, redirect_pc, flush, br_done, br_taken,
               flags, err, pending
    );

endinterface

// File: rtl/vmicro16_cond_eval.sv
// Combinational branch-condition evaluator: NZCV flags and a BR condition
// code in, taken out. Unknown codes resolve not-taken.
module vmicro16_cond_eval
    import vmicro16_branch_resolve_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [7:0] cond,
    output logic       taken
);

    logic z_s;
    logic lt_s;
    logic unused_c_s;

    assign unused_c_s = flags[VMICRO16_SFLAG_C];

    // Decode the condition code against the supplied flags
    always_comb begin
        z_s   = flags[VMICRO16_SFLAG_Z];
        lt_s  = flags[VMICRO16_SFLAG_N] ^ flags[VMICRO16_SFLAG_V];
        taken = 1'b0;
        case (cond)
            VMICRO16_OP_BR_U:  taken = 1'b1;
            VMICRO16_OP_BR_E:  taken = z_s;
            VMICRO16_OP_BR_NE: taken = ~z_s;
            VMICRO16_OP_BR_L:  taken = lt_s;
            VMICRO16_OP_BR_GE: taken = ~lt_s;
            VMICRO16_OP_BR_G:  taken = ~z_s & ~lt_s;
            VMICRO16_OP_BR_LE: taken = z_s | lt_s;
            default:           taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/vmicro16_branch_resolve.sv
// Branch-resolution stage: tracks in-flight compares, holds a branch until all
// older compares retire, then evaluates it and issues a one-cycle redirect.
module vmicro16_branch_resolve
    import vmicro16_branch_resolve_pkg::*;
#(
    parameter int PC_WIDTH     = 16,
    parameter int MAX_INFLIGHT = 3
) (
    input logic                     clk,
    input logic                     reset,
    vmicro16_branch_resolve_if.slave bus
);

    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_INFLIGHT);

    br_state_t           state_r, state_s;
    logic [CNT_W-1:0]    pending_r, pending_s;
    logic [CNT_W-1:0]    wait_cnt_r, wait_cnt_s;
    logic [7:0]          cond_r, cond_s;
    logic [PC_WIDTH-1:0] target_r, target_s;
    logic [3:0]          flags_r, flags_s;
    logic                err_r, err_s;
    logic                br_ready_r, br_ready_s;
    logic                br_done_r, br_done_s;
    logic                br_taken_r, br_taken_s;
    logic                redir_valid_r, redir_valid_s;
    logic                flush_r, flush_s;
    logic [PC_WIDTH-1:0] redir_pc_r, redir_pc_s;
    logic                retire_ok_s;
    logic                taken_s;

    // Evaluation always uses the architectural flags register, never cmp_flags
    vmicro16_cond_eval u_cond_eval (
        .flags (flags_r),
        .cond  (cond_r),
        .taken (taken_s)
    );

    // In-flight compare counter, overflow/underflow error and flags register
    always_comb begin
        pending_s   = pending_r;
        err_s       = err_r;
        retire_ok_s = bus.cmp_valid && (pending_r != CNT_ZERO);
        flags_s     = bus.cmp_valid ? bus.cmp_flags : flags_r;
        if (bus.cmp_issue && !bus.cmp_valid) begin
            if (pending_r == CNT_MAX) begin
                err_s = 1'b1;
            end else begin
                pending_s = pending_r + CNT_ONE;
            end
        end else if (!bus.cmp_issue && bus.cmp_valid) begin
            if (pending_r == CNT_ZERO) begin
                err_s = 1'b1;
            end else begin
                pending_s = pending_r - CNT_ONE;
            end
        end else begin
            pending_s = pending_r;
        end
    end

    // Branch FSM next-state and registered-output values
    always_comb begin
        state_s       = state_r;
        wait_cnt_s    = wait_cnt_r;
        cond_s        = cond_r;
        target_s      = target_r;
        br_done_s     = 1'b0;
        br_taken_s    = 1'b0;
        redir_valid_s = 1'b0;
        flush_s       = 1'b0;
        redir_pc_s    = redir_pc_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.br_valid) begin
                    cond_s   = bus.br_cond;
                    target_s = bus.br_target;
                    // A same-cycle issue is younger than the branch and is not waited on
                    wait_cnt_s = pending_r - (retire_ok_s ? CNT_ONE : CNT_ZERO);
                    state_s    = (wait_cnt_s != CNT_ZERO) ? ST_WAIT : ST_EVAL;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (bus.cmp_valid && (wait_cnt_r != CNT_ZERO)) begin
                    wait_cnt_s = wait_cnt_r - CNT_ONE;
                    state_s    = (wait_cnt_s == CNT_ZERO) ? ST_EVAL : ST_WAIT;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_EVAL: begin
                br_done_s     = 1'b1;
                br_taken_s    = taken_s;
                redir_valid_s = taken_s;
                flush_s       = taken_s;
                redir_pc_s    = target_r;
                state_s       = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        br_ready_s = (state_s == ST_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            pending_r     <= CNT_ZERO;
            wait_cnt_r    <= CNT_ZERO;
            cond_r        <= 8'h00;
            target_r      <= {PC_WIDTH{1'b0}};
            flags_r       <= 4'b0000;
            err_r         <= 1'b0;
            br_ready_r    <= 1'b1;
            br_done_r     <= 1'b0;
            br_taken_r    <= 1'b0;
            redir_valid_r <= 1'b0;
            flush_r       <= 1'b0;
            redir_pc_r    <= {PC_WIDTH{1'b0}};
        end else begin
            state_r       <= state_s;
            pending_r     <= pending_s;
            wait_cnt_r    <= wait_cnt_s;
            cond_r        <= cond_s;
            target_r      <= target_s;
            flags_r       <= flags_s;
            err_r         <= err_s;
            br_ready_r    <= br_ready_s;
            br_done_r     <= br_done_s;
            br_taken_r    <= br_taken_s;
            redir_valid_r <= redir_valid_s;
            flush_r       <= flush_s;
            redir_pc_r    <= redir_pc_s;
        end
    end

    assign bus.br_ready       = br_ready_r;
    assign bus.br_done        = br_done_r;
    assign bus.br_taken       = br_taken_r;
    assign bus.redirect_valid = redir_valid_r;
    assign bus.flush          = flush_r;
    assign bus.redirect_pc    = redir_pc_r;
    assign bus.flags          = flags_r;
    assign bus.err            = err_r;
    assign bus.pending        = pending_r;

endmodule

// File: tb/tb_vmicro16_branch_resolve.sv
// Directed bench for vmicro16_branch_resolve: expected resolutions are queued
// at issue and a monitor checks each br_done pulse, its cycle and redirect.
module tb_vmicro16_branch_resolve;
    import vmicro16_branch_resolve_pkg::*;

    localparam int PC_WIDTH     = 16;
    localparam int MAX_INFLIGHT = 3;
    localparam int CNT_W        = $clog2(MAX_INFLIGHT + 1);

    typedef struct packed {
        logic        taken;
        logic [15:0] pc;
        logic [31:0] cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int unsigned cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vmicro16_branch_resolve_if #(.PC_WIDTH(PC_WIDTH), .CNT_W(CNT_W)) bus ();

    vmicro16_branch_resolve #(.PC_WIDTH(PC_WIDTH), .MAX_INFLIGHT(MAX_INFLIGHT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected resolution lands 'ofs' edges after the current cycle count
    task automatic expect_br(input logic taken, input logic [15:0] pc, input int ofs);
        exp_t e;
        e.taken = taken;
        e.pc    = pc;
        e.cyc   = cyc + ofs;
        exp_q.push_back(e);
    endtask

    task automatic drive_br(input logic [7:0] cond, input logic [15:0] target);
        bus.br_valid  = 1'b1;
        bus.br_cond   = cond;
        bus.br_target = target;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.br_done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_br_done: got br_done=1 expected none (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("br_taken", 32'(bus.br_taken), 32'(e.taken));
                    check("redirect_valid", 32'(bus.redirect_valid), 32'(e.taken));
                    check("flush", 32'(bus.flush), 32'(e.taken));
                    check("done_cycle", cyc, e.cyc);
                    if (e.taken) check("redirect_pc", 32'(bus.redirect_pc), 32'(e.pc));
                end
            end else if (bus.redirect_valid !== 1'b0 || bus.flush !== 1'b0) begin
                n_vec++;
                n_err++;
                $display("FAIL stray_redirect: got redirect=%b flush=%b expected 0 (cycle %0d)",
                         bus.redirect_valid, bus.flush, cyc);
            end
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.cmp_issue = 1'b0;
        bus.cmp_valid = 1'b0;
        bus.cmp_flags = 4'b0000;
        bus.br_valid  = 1'b0;
        bus.br_cond   = 8'h00;
        bus.br_target = 16'h0000;
        tick();
        tick();
        reset = 1'b0;
        check("rst_br_ready", 32'(bus.br_ready), 32'd1);
        check("rst_flags", 32'(bus.flags), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_pending", 32'(bus.pending), 32'd0);
        check("rst_redirect_pc", 32'(bus.redirect_pc), 32'd0);
        check("rst_br_done", 32'(bus.br_done), 32'd0);
        fork
            monitor();
        join_none

        // Unconditional branch, no compares in flight: latency 2
        drive_br(VMICRO16_OP_BR_U, 16'h0040);
        expect_br(1'b1, 16'h0040, 2);
        tick();
        bus.br_valid = 1'b0;
        check("t1_ready_eval", 32'(bus.br_ready), 32'd0);
        tick();
        check("t1_ready_done", 32'(bus.br_ready), 32'd1);
        tick();
        check("t1_err", 32'(bus.err), 32'd0);

        // Branch L waits for one older compare retiring with N=1
        bus.cmp_issue = 1'b1;
        tick();
        bus.cmp_issue = 1'b0;
        drive_br(VMICRO16_OP_BR_L, 16'h0100);
        expect_br(1'b1, 16'h0100, 5);
        tick();
        bus.br_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t2_ready_wait", 32'(bus.br_ready), 32'd0);
            if (i < 2) tick();
        end
        bus.cmp_valid = 1'b1;
        bus.cmp_flags = 4'b1000;
        tick();
        bus.cmp_valid = 1'b0;
        check("t2_flags", 32'(bus.flags), 32'h8);
        check("t2_ready_eval", 32'(bus.br_ready), 32'd0);
        tick();
        check("t2_ready_done", 32'(bus.br_ready), 32'd1);

        // Flags 0000: G taken, L and E not taken, back to back
        bus.cmp_issue = 1'b1;
        tick();
        bus.cmp_issue = 1'b0;
        bus.cmp_valid = 1'b1;
        bus.cmp_flags = 4'b0000;
        tick();
        bus.cmp_valid = 1'b0;
        check("t3_pending", 32'(bus.pending), 32'd0);
        check("t3_flags", 32'(bus.flags), 32'd0);
        drive_br(VMICRO16_OP_BR_G, 16'h0200);
        expect_br(1'b1, 16'h0200, 2);
        tick();
        bus.br_valid = 1'b0;
        tick();
        drive_br(VMICRO16_OP_BR_L, 16'h0210);
        expect_br(1'b0, 16'h0210, 2);
        tick();
        bus.br_valid = 1'b0;
        tick();
        drive_br(VMICRO16_OP_BR_E, 16'h0220);
        expect_br(1'b0, 16'h0220, 2);
        tick();
        bus.br_valid = 1'b0;
        tick();

        // Same-cycle issue is younger; a retire during EVAL does not affect it
        drive_br(VMICRO16_OP_BR_E, 16'h0230);
        bus.cmp_issue = 1'b1;
        expect_br(1'b0, 16'h0230, 2);
        tick();
        bus.br_valid  = 1'b0;
        bus.cmp_issue = 1'b0;
        bus.cmp_valid = 1'b1;
        bus.cmp_flags = 4'b0100;
        tick();
        bus.cmp_valid = 1'b0;
        check("t3_flags_after_eval", 32'(bus.flags), 32'h4);
        check("t3_pending_after_eval", 32'(bus.pending), 32'd0);
        check("t3_err", 32'(bus.err), 32'd0);
        drive_br(VMICRO16_OP_BR_E, 16'h0240);
        expect_br(1'b1, 16'h0240, 2);
        tick();
        bus.br_valid = 1'b0;
        tick();

        // Held in WAIT on one older compare while a younger one issues
        bus.cmp_issue = 1'b1;
        tick();
        bus.cmp_issue = 1'b0;
        bus.cmp_valid = 1'b1;
        bus.cmp_flags = 4'b0000;
        tick();
        bus.cmp_valid = 1'b0;
        bus.cmp_issue = 1'b1;
        tick();
        bus.cmp_issue = 1'b0;
        drive_br(VMICRO16_OP_BR_E, 16'h0400);
        expect_br(1'b1, 16'h0400, 4);
        tick();
        bus.br_valid  = 1'b0;
        bus.cmp_issue = 1'b1;
        tick();
        bus.cmp_issue = 1'b0;
        check("t4_ready_wait", 32'(bus.br_ready), 32'd0);
        check("t4_pending_two", 32'(bus.pending), 32'd2);
        bus.cmp_valid = 1'b1;
        bus.cmp_flags = 4'b0100;
        tick();
        bus.cmp_valid = 1'b0;
        tick();
        check("t4_pending_end", 32'(bus.pending), 32'd1);
        check("t4_err", 32'(bus.err), 32'd0);

        // Overflow: fourth issue saturates at 3 and sets sticky err
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.cmp_issue = 1'b1;
            tick();
            if (i == 2) check("t5_err_at_max", 32'(bus.err), 32'd0);
        end
        bus.cmp_issue = 1'b0;
        check("t5_pending_sat", 32'(bus.pending), 32'd3);
        check("t5_err_set", 32'(bus.err), 32'd1);
        tick();
        tick();
        bus.cmp_valid = 1'b1;
        bus.cmp_flags = 4'b0011;
        tick();
        bus.cmp_valid = 1'b0;
        check("t5_pending_dec", 32'(bus.pending), 32'd2);
        check("t5_err_sticky", 32'(bus.err), 32'd1);

        // Reset during WAIT drops the branch without a redirect
        drive_br(VMICRO16_OP_BR_U, 16'h0500);
        tick();
        bus.br_valid = 1'b0;
        check("t5_ready_wait", 32'(bus.br_ready), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_rst_ready", 32'(bus.br_ready), 32'd1);
        check("t5_rst_err", 32'(bus.err), 32'd0);
        check("t5_rst_pending", 32'(bus.pending), 32'd0);
        check("t5_rst_flags", 32'(bus.flags), 32'd0);
        for (int i = 0; i < 4; i++) tick();

        // Retire with nothing in flight: ignored count, err set, flags still written
        bus.cmp_valid = 1'b1;
        bus.cmp_flags = 4'b1010;
        tick();
        bus.cmp_valid = 1'b0;
        check("t6_err", 32'(bus.err), 32'd1);
        check("t6_pending", 32'(bus.pending), 32'd0);
        check("t6_flags", 32'(bus.flags), 32'hA);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: got %0d unresolved branches expected 0", exp_q.size());
        end
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
